// File: rtl/bus_timer_irq.sv
// Memory-mapped 16-bit down-counter timer with prescaler, capture and a level interrupt.
// It decodes an 8-byte window at BASE on the CPU bus, takes byte writes and returns registered reads.
module bus_timer_irq #(
  parameter logic [15:0] BASE    = 16'hFF00,
  parameter int          PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        sel,
  output logic        intr
);

  logic [2:0]         offset;
  logic               wr;
  logic               rd;
  logic               en;
  logic               auto_rl;
  logic               ie;
  logic               expired;
  logic [15:0]        reload;
  logic [15:0]        count;
  logic [15:0]        capt;
  logic [7:0]         prescale;
  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W+7:0] presc_ext;
  logic [PRESC_W-1:0] presc_limit;
  logic               tick;
  logic               at_zero;
  logic               wr_ctrl;
  logic               wr_status;
  logic               wr_rel_l;
  logic               wr_rel_h;
  logic               wr_presc;
  logic [7:0]         rdata;

  assign sel     = (address[15:3] == BASE[15:3]);
  assign offset  = address[2:0];
  assign wr      = sel && !read;
  assign rd      = sel && read;

  assign wr_ctrl   = wr && (offset == 3'd0);
  assign wr_status = wr && (offset == 3'd1);
  assign wr_rel_l  = wr && (offset == 3'd2);
  assign wr_rel_h  = wr && (offset == 3'd3);
  assign wr_presc  = wr && (offset == 3'd6);

  // PRESCALE is zero-extended or truncated to the prescaler width.
  assign presc_ext   = {{PRESC_W{1'b0}}, prescale};
  assign presc_limit = presc_ext[PRESC_W-1:0];
  assign tick        = en && (presc_cnt == presc_limit);
  assign at_zero     = (count == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      count     <= 16'd0;
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      ie        <= 1'b0;
      expired   <= 1'b0;
      reload    <= 16'd0;
      capt      <= 16'd0;
      prescale  <= 8'd0;
      intr      <= 1'b0;
    end else begin
      if (wr_rel_h)
        presc_cnt <= '0;
      else if (en)
        presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);

      // A RELOAD_H write overrides whatever the tick would have done to COUNT.
      if (wr_rel_h)
        count <= {din, reload[7:0]};
      else if (tick) begin
        if (!at_zero)
          count <= count - 16'd1;
        else if (auto_rl)
          count <= reload;
      end

      // A CTRL write overrides the one-shot auto-disable on the same edge.
      if (wr_ctrl) begin
        en      <= din[0];
        auto_rl <= din[1];
        ie      <= din[2];
      end else if (tick && at_zero && !auto_rl)
        en <= 1'b0;

      if (tick && at_zero)
        expired <= 1'b1;
      else if (wr_status && din[0])
        expired <= 1'b0;

      if (wr_ctrl && din[3])
        capt <= count;
      if (wr_rel_l)
        reload[7:0] <= din;
      if (wr_rel_h)
        reload[15:8] <= din;
      if (wr_presc)
        prescale <= din;

      intr <= expired && ie;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (offset)
      3'd0: rdata = {5'b0, ie, auto_rl, en};
      3'd1: rdata = {7'b0, expired};
      3'd2: rdata = reload[7:0];
      3'd3: rdata = reload[15:8];
      3'd4: rdata = capt[7:0];
      3'd5: rdata = capt[15:8];
      3'd6: rdata = prescale;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      dout <= 8'h00;
    else if (rd)
      dout <= rdata;
  end

endmodule

// File: tb/tb_bus_timer_irq.sv
// Directed bench for bus_timer_irq: bus signals change on negedge, results are sampled on the
// following negedge, and expected values are hand-computed cycle by cycle.
module tb_bus_timer_irq;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] IDLE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [15:0] address;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        sel;
  logic        intr;

  int tests_run = 0;
  int tests_failed = 0;

  bus_timer_irq #(.BASE(BASE), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .read(read), .address(address),
    .din(din), .dout(dout), .sel(sel), .intr(intr)
  );

  always #5 clk = ~clk;

  // Bus tasks start and end on a negedge; the access is sampled on the posedge in between.
  task automatic bus_write(input logic [2:0] off, input logic [7:0] data);
    address = BASE | {13'b0, off};
    read    = 1'b0;
    din     = data;
    @(negedge clk);
    address = IDLE;
    read    = 1'b1;
    din     = 8'h00;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [7:0] data);
    address = BASE | {13'b0, off};
    read    = 1'b1;
    @(negedge clk);
    data    = dout;
    address = IDLE;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1; read = 1'b1; address = IDLE; din = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_dout: got %h, expected 00", dout); end
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_intr: got %b, expected 0", intr); end
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), v);
      tests_run++;
      if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_read%0d: got %h, expected 00", i, v); end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] v;
    bus_write(3'd2, 8'h03);
    bus_write(3'd3, 8'h00);
    bus_write(3'd6, 8'h01);
    bus_write(3'd0, 8'h07);
    repeat (7) @(negedge clk);
    bus_read(3'd1, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL periodic_exp_early: got %h, expected 00", v); end
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL periodic_intr_early: got %b, expected 0", intr); end
    bus_write(3'd0, 8'h0F);
    tests_run++;
    if (intr !== 1'b1) begin tests_failed++; $display("[TB] FAIL periodic_intr: got %b, expected 1", intr); end
    bus_read(3'd1, v);
    tests_run++;
    if (v !== 8'h01) begin tests_failed++; $display("[TB] FAIL periodic_exp: got %h, expected 01", v); end
    bus_read(3'd4, v);
    tests_run++;
    if (v !== 8'h03) begin tests_failed++; $display("[TB] FAIL periodic_reload_lo: got %h, expected 03", v); end
    bus_read(3'd5, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL periodic_reload_hi: got %h, expected 00", v); end
    bus_read(3'd0, v);
    tests_run++;
    if (v !== 8'h07) begin tests_failed++; $display("[TB] FAIL periodic_ctrl: got %h, expected 07", v); end
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h01);
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL periodic_stop_intr: got %b, expected 0", intr); end
  endtask

  task automatic test_oneshot();
    logic [7:0] v;
    bus_write(3'd6, 8'h00);
    bus_write(3'd2, 8'h02);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h05);
    repeat (3) @(negedge clk);
    bus_read(3'd1, v);
    tests_run++;
    if (v !== 8'h01) begin tests_failed++; $display("[TB] FAIL oneshot_exp: got %h, expected 01", v); end
    bus_read(3'd0, v);
    tests_run++;
    if (v !== 8'h04) begin tests_failed++; $display("[TB] FAIL oneshot_ctrl: got %h, expected 04", v); end
    tests_run++;
    if (intr !== 1'b1) begin tests_failed++; $display("[TB] FAIL oneshot_intr: got %b, expected 1", intr); end
    bus_write(3'd0, 8'h0C);
    bus_read(3'd4, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL oneshot_count_lo: got %h, expected 00", v); end
    bus_read(3'd5, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL oneshot_count_hi: got %h, expected 00", v); end
  endtask

  task automatic test_clear_collision();
    logic [7:0] v;
    bus_write(3'd1, 8'h01);
    bus_write(3'd2, 8'h01);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h05);
    @(negedge clk);
    bus_write(3'd1, 8'h01);
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL collide_intr_before: got %b, expected 0", intr); end
    bus_write(3'd1, 8'h01);
    tests_run++;
    if (intr !== 1'b1) begin tests_failed++; $display("[TB] FAIL collide_set_wins: got %b, expected 1", intr); end
    @(negedge clk);
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL collide_intr_drop: got %b, expected 0", intr); end
    bus_read(3'd1, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL collide_status: got %h, expected 00", v); end
  endtask

  task automatic test_ctrl_collision();
    logic [7:0] v;
    bus_write(3'd2, 8'h01);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h01);
    @(negedge clk);
    bus_write(3'd0, 8'h01);
    bus_read(3'd0, v);
    tests_run++;
    if (v !== 8'h01) begin tests_failed++; $display("[TB] FAIL ctrl_write_wins: got %h, expected 01", v); end
    bus_read(3'd0, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL ctrl_second_expiry: got %h, expected 00", v); end
    bus_read(3'd1, v);
    tests_run++;
    if (v !== 8'h01) begin tests_failed++; $display("[TB] FAIL ctrl_exp: got %h, expected 01", v); end
    bus_write(3'd1, 8'h01);
  endtask

  task automatic test_capture();
    logic [7:0] v;
    bus_write(3'd2, 8'h34);
    bus_write(3'd3, 8'h12);
    bus_write(3'd0, 8'h08);
    bus_read(3'd4, v);
    tests_run++;
    if (v !== 8'h34) begin tests_failed++; $display("[TB] FAIL capt_lo: got %h, expected 34", v); end
    bus_read(3'd5, v);
    tests_run++;
    if (v !== 8'h12) begin tests_failed++; $display("[TB] FAIL capt_hi: got %h, expected 12", v); end
    bus_write(3'd6, 8'h00);
    bus_write(3'd0, 8'h01);
    repeat (4) @(negedge clk);
    bus_read(3'd4, v);
    tests_run++;
    if (v !== 8'h34) begin tests_failed++; $display("[TB] FAIL capt_hold_lo: got %h, expected 34", v); end
    bus_read(3'd5, v);
    tests_run++;
    if (v !== 8'h12) begin tests_failed++; $display("[TB] FAIL capt_hold_hi: got %h, expected 12", v); end
    bus_write(3'd0, 8'h09);
    bus_read(3'd4, v);
    tests_run++;
    if (v !== 8'h2E) begin tests_failed++; $display("[TB] FAIL capt_tick_lo: got %h, expected 2e", v); end
    bus_read(3'd5, v);
    tests_run++;
    if (v !== 8'h12) begin tests_failed++; $display("[TB] FAIL capt_tick_hi: got %h, expected 12", v); end
    bus_write(3'd0, 8'h00);
  endtask

  task automatic test_reload_collision();
    logic [7:0] v;
    bus_write(3'd0, 8'h01);
    @(negedge clk);
    bus_write(3'd2, 8'h10);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h08);
    bus_read(3'd4, v);
    tests_run++;
    if (v !== 8'h10) begin tests_failed++; $display("[TB] FAIL load_wins_lo: got %h, expected 10", v); end
    bus_read(3'd5, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL load_wins_hi: got %h, expected 00", v); end
  endtask

  task automatic test_decode();
    logic [7:0] v;
    bus_write(3'd6, 8'h5A);
    bus_read(3'd6, v);
    tests_run++;
    if (v !== 8'h5A) begin tests_failed++; $display("[TB] FAIL decode_presc: got %h, expected 5a", v); end
    address = 16'hFF07; read = 1'b1; #1;
    tests_run++;
    if (sel !== 1'b1) begin tests_failed++; $display("[TB] FAIL decode_sel_in: got %b, expected 1", sel); end
    address = 16'hFEFF; read = 1'b0; din = 8'hA5; #1;
    tests_run++;
    if (sel !== 1'b0) begin tests_failed++; $display("[TB] FAIL decode_sel_feff: got %b, expected 0", sel); end
    @(negedge clk);
    address = 16'hFF08; din = 8'h06; #1;
    tests_run++;
    if (sel !== 1'b0) begin tests_failed++; $display("[TB] FAIL decode_sel_ff08: got %b, expected 0", sel); end
    @(negedge clk);
    address = 16'hFEFE; din = 8'h11;
    @(negedge clk);
    address = 16'hFF08; read = 1'b1; din = 8'h00;
    @(negedge clk);
    tests_run++;
    if (dout !== 8'h5A) begin tests_failed++; $display("[TB] FAIL decode_dout_hold: got %h, expected 5a", dout); end
    address = IDLE;
    bus_read(3'd0, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL decode_ctrl: got %h, expected 00", v); end
    bus_read(3'd6, v);
    tests_run++;
    if (v !== 8'h5A) begin tests_failed++; $display("[TB] FAIL decode_presc_kept: got %h, expected 5a", v); end
    bus_write(3'd7, 8'hFF);
    bus_read(3'd7, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL decode_reserved: got %h, expected 00", v); end
  endtask

  task automatic test_reset_midcount();
    logic [7:0] v;
    bus_write(3'd6, 8'h00);
    bus_write(3'd2, 8'h01);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h07);
    repeat (3) @(negedge clk);
    tests_run++;
    if (intr !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_pre_intr: got %b, expected 1", intr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_intr: got %b, expected 0", intr); end
    tests_run++;
    if (dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_dout: got %h, expected 00", dout); end
    bus_read(3'd0, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_ctrl: got %h, expected 00", v); end
    bus_read(3'd1, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_status: got %h, expected 00", v); end
    bus_read(3'd2, v);
    tests_run++;
    if (v !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_reload: got %h, expected 00", v); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (intr !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_intr_late: got %b, expected 0", intr); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_clear_collision();
    test_ctrl_collision();
    test_capture();
    test_reload_collision();
    test_decode();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
